// File: rtl/times_table_ctrl_if.sv
// Operand request, times-table memory and result channels of times_table_ctrl.
// The master modport is the controller; the slave modport is its environment.
interface times_table_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_a;
  logic [2:0] in_b;
  logic       mem_en;
  logic [2:0] mem_a;
  logic [2:0] mem_b;
  logic [5:0] mem_out;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;
  logic [2:0] res_a;
  logic [2:0] res_b;

  modport master (
    input  in_valid, in_a, in_b, mem_out, res_ready,
    output in_ready, mem_en, mem_a, mem_b, res_valid, res_data, res_a, res_b
  );

  modport slave (
    output in_valid, in_a, in_b, mem_out, res_ready,
    input  in_ready, mem_en, mem_a, mem_b, res_valid, res_data, res_a, res_b
  );
endinterface

// File: rtl/times_table_ctrl.sv
// Times-table lookup controller: issues memory reads, buffers products in order.
// Optional macro TIMES_TABLE_CHECK_EN adds an a*b cross-check driving the sticky err flag.
module times_table_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  times_table_ctrl_if.master  bus,
  output logic [7:0]          res_count,
  output logic                err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [5:0]    data_q [DEPTH];
  logic [2:0]    a_q    [DEPTH];
  logic [2:0]    b_q    [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, occ;
  logic          infl_q, infl_d;
  logic [2:0]    infl_a_q, infl_b_q;
  logic [7:0]    res_count_q, res_count_d;
  logic          accept, push, pop;

  // in_ready sees only registered occupancy plus the outstanding read, and rst
  assign occ          = cnt_q + CW'(infl_q);
  assign bus.in_ready = !rst && (occ < CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.mem_en   = accept;
  assign bus.mem_a    = bus.in_a;
  assign bus.mem_b    = bus.in_b;

  assign push          = infl_q;
  assign bus.res_valid = (cnt_q != '0);
  assign pop           = bus.res_valid && bus.res_ready;
  assign bus.res_data  = data_q[rd_ptr_q];
  assign bus.res_a     = a_q[rd_ptr_q];
  assign bus.res_b     = b_q[rd_ptr_q];
  assign res_count     = res_count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    infl_d      = accept;
    res_count_d = res_count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      res_count_d = res_count_q + 8'd1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_a_q    <= '0;
      infl_b_q    <= '0;
      res_count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      res_count_q <= res_count_d;
      if (accept) begin
        infl_a_q <= bus.in_a;
        infl_b_q <= bus.in_b;
      end
      if (push) begin
        data_q[wr_ptr_q] <= bus.mem_out;
        a_q[wr_ptr_q]    <= infl_a_q;
        b_q[wr_ptr_q]    <= infl_b_q;
      end
    end
  end

`ifdef TIMES_TABLE_CHECK_EN
  logic       err_q;
  logic [5:0] ref_prod;

  assign ref_prod = {3'b000, infl_a_q} * {3'b000, infl_b_q};
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (push && (bus.mem_out != ref_prod)) err_q <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_times_table_ctrl.sv
// Directed, table-driven bench for times_table_ctrl with a behavioural times-table memory.
module tb_times_table_ctrl;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] prod;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] res_count;
  logic       err;
  logic       bad = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         got;
  int         exp_err;
  vec_t       expq[$];
  vec_t       vecs[6];
  vec_t       bp[4];

  times_table_ctrl_if ifc ();

  times_table_ctrl #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .res_count (res_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory model: product of the address one cycle after mem_en; 'bad' corrupts 4x4.
  always @(posedge clk) begin
    if (ifc.mem_en)
      ifc.mem_out <= (bad && ifc.mem_a == 3'd4 && ifc.mem_b == 3'd4) ? 6'd20
                   : ({3'b000, ifc.mem_a} * {3'b000, ifc.mem_b});
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic collect();
    vec_t e;
    if (ifc.res_valid && ifc.res_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = expq.pop_front();
        check("order_data", ifc.res_data, e.prod);
        check("order_a", ifc.res_a, e.a);
        check("order_b", ifc.res_b, e.b);
        got++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_a      = 3'd1;
    ifc.in_b      = 3'd1;
    ifc.res_ready = 1'b0;
    cyc();
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_mem_en", ifc.mem_en, 0);
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", ifc.in_ready, 1);
    check("post_rst_res_valid", ifc.res_valid, 0);
    check("post_rst_res_count", res_count, 0);
    check("post_rst_err", err, 0);
    check("post_rst_res_data", ifc.res_data, 0);
    expq.delete();
    got = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 3'd5, 6'd15};
    vecs[1] = '{3'd0, 3'd0, 6'd0};
    vecs[2] = '{3'd7, 3'd7, 6'd49};
    vecs[3] = '{3'd1, 3'd6, 6'd6};
    vecs[4] = '{3'd5, 3'd4, 6'd20};
    vecs[5] = '{3'd2, 3'd7, 6'd14};
    bp[0]   = '{3'd1, 3'd2, 6'd2};
    bp[1]   = '{3'd3, 3'd3, 6'd9};
    bp[2]   = '{3'd2, 3'd5, 6'd10};
    bp[3]   = '{3'd6, 3'd6, 6'd36};
    ifc.mem_out = '0;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    ifc.res_ready = 1'b0;
`ifdef TIMES_TABLE_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif

    // Single requests: latency, fields, count.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ifc.in_valid  = 1'b1;
      ifc.in_a      = vecs[k].a;
      ifc.in_b      = vecs[k].b;
      ifc.res_ready = 1'b1;
      #1;
      check("vec_mem_en", ifc.mem_en, 1);
      check("vec_mem_a", ifc.mem_a, vecs[k].a);
      check("vec_mem_b", ifc.mem_b, vecs[k].b);
      cyc();
      ifc.in_valid = 1'b0;
      #1;
      check("vec_mem_en_idle", ifc.mem_en, 0);
      check("vec_valid_t1", ifc.res_valid, 0);
      cyc();
      check("vec_valid_t2", ifc.res_valid, 1);
      check("vec_data", ifc.res_data, vecs[k].prod);
      check("vec_a", ifc.res_a, vecs[k].a);
      check("vec_b", ifc.res_b, vecs[k].b);
      cyc();
      check("vec_valid_after_pop", ifc.res_valid, 0);
      check("vec_count", res_count, k + 1);
    end

    // 64 back-to-back requests sweeping {a,b}.
    do_reset();
    ifc.res_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      expq.push_back('{3'(i >> 3), 3'(i & 7), 6'((i >> 3) * (i & 7))});
    end
    for (int i = 0; i < 64; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_a = 3'(i >> 3);
      ifc.in_b = 3'(i & 7);
      #1;
      check("sweep_in_ready", ifc.in_ready, 1);
      collect();
      cyc();
    end
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (got == 63) check("sweep_last_data", ifc.res_data, 49);
      collect();
      cyc();
    end
    check("sweep_got", got, 64);
    check("sweep_count", res_count, 64);

    // Backpressure: exactly DEPTH accepted, head held, then ordered drain.
    do_reset();
    ifc.res_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_a = (k < 4) ? bp[k].a : 3'd5;
      ifc.in_b = (k < 4) ? bp[k].b : 3'd5;
      #1;
      check("bp_in_ready", ifc.in_ready, (k < 4) ? 1 : 0);
      if (k >= 2) begin
        check("bp_hold_valid", ifc.res_valid, 1);
        check("bp_hold_data", ifc.res_data, 2);
      end
      cyc();
    end
    ifc.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) expq.push_back(bp[k]);
    ifc.res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      collect();
      cyc();
    end
    check("bp_got", got, 4);
    check("bp_count", res_count, 4);

    // Mid-operation reset with two buffered and one in flight.
    do_reset();
    ifc.res_ready = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_a = 3'd2;
    ifc.in_b = 3'd3;
    cyc();
    ifc.in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    check("mr_pre_count", res_count, 1);
    ifc.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_a = 3'(4 + k);
      ifc.in_b = 3'd5;
      cyc();
    end
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_pre_valid", ifc.res_valid, 1);
    check("mr_pre_data", ifc.res_data, 20);
    cyc();
    rst = 1'b0;
    #1;
    check("mr_valid", ifc.res_valid, 0);
    check("mr_count", res_count, 0);
    check("mr_in_ready", ifc.in_ready, 1);
    ifc.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("mr_no_stale", ifc.res_valid, 0);
      cyc();
    end

    // Corrupted memory reply for 4x4.
    do_reset();
    bad = 1'b1;
    ifc.res_ready = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_a = 3'd4;
    ifc.in_b = 3'd4;
    cyc();
    ifc.in_valid = 1'b0;
    #1;
    check("err_before_capture", err, 0);
    cyc();
    check("err_set", err, exp_err);
    check("err_data", ifc.res_data, 20);
    ifc.in_valid = 1'b1;
    ifc.in_a = 3'd2;
    ifc.in_b = 3'd2;
    cyc();
    ifc.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    check("err_sticky", err, exp_err);
    bad = 1'b0;
    do_reset();

    // res_count wrap after 256 deliveries.
    ifc.res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_a = 3'(i >> 3);
      ifc.in_b = 3'(i & 7);
      cyc();
    end
    ifc.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    check("wrap_count", res_count, 0);
    check("wrap_valid", ifc.res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
